// File: rtl/ldpc_pkg.sv
// Shared definitions for the hard-decision bit-flipping LDPC decoder:
// FSM encoding, default code dimensions and H-matrix row extraction.
package ldpc_pkg;

  localparam int LDPC_N = 11;
  localparam int LDPC_K = 6;

  // Upper bounds for the generic row helper; callers zero-extend into these.
  localparam int LDPC_MAX_N = 64;
  localparam int LDPC_MAX_H = 4096;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYND = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Row r of an m-row, n-column flattened H lives at bits [(m-r)*n-1 -: n].
  function automatic logic [LDPC_MAX_N-1:0] ldpc_row(
    input logic [LDPC_MAX_H-1:0] h,
    input int                    n,
    input int                    m,
    input int                    r
  );
    return LDPC_MAX_N'(h >> ((m - r - 1) * n));
  endfunction

endpackage

// File: rtl/ldpc_syndrome.sv
// Combinational syndrome and per-bit unsatisfied-check counts for a
// flattened H matrix and a working codeword.
module ldpc_syndrome
  import ldpc_pkg::*;
#(
  parameter int N  = LDPC_N,
  parameter int M  = LDPC_N - LDPC_K,
  parameter int CW = $clog2(M + 1)
) (
  input  logic [M*N-1:0]  i_h,
  input  logic [N-1:0]    i_codeword,
  output logic [M-1:0]    o_syndrome,
  output logic [N*CW-1:0] o_unsat
);

  logic [N-1:0]  w_rows [M];
  logic [CW-1:0] w_cnt;

  always_comb begin
    for (int r = 0; r < M; r++) begin
      w_rows[r] = N'(ldpc_row(LDPC_MAX_H'(i_h), N, M, r));
    end
  end

  always_comb begin
    o_syndrome = '0;
    o_unsat    = '0;
    w_cnt      = '0;
    for (int r = 0; r < M; r++) begin
      o_syndrome[r] = ^(w_rows[r] & i_codeword);
    end
    // unsat[j] counts failing checks that involve bit j.
    for (int j = 0; j < N; j++) begin
      w_cnt = '0;
      for (int r = 0; r < M; r++) begin
        w_cnt = w_cnt + CW'(o_syndrome[r] & w_rows[r][j]);
      end
      o_unsat[j*CW +: CW] = w_cnt;
    end
  end

endmodule

// File: rtl/ldpc_bitflip_decode.sv
// Iterative single-bit-flip LDPC decoder (IDLE -> SYND -> EVAL -> ... -> DONE).
// Optional macro LDPC_FLIP_MASK_EN adds a flip_mask output of toggled bits.
module ldpc_bitflip_decode
  import ldpc_pkg::*;
#(
  parameter int N        = LDPC_N,
  parameter int K        = LDPC_K,
  parameter int MAX_ITER = 8,
  parameter int ITER_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [N-1:0]         received,
  input  logic [(N-K)*N-1:0]   parity_check,
  output logic [N-1:0]         codeword,
  output logic [N-K-1:0]       syndrome,
  output logic [ITER_W-1:0]    iter,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_ok
`ifdef LDPC_FLIP_MASK_EN
  ,
  output logic [N-1:0]         flip_mask
`endif
);

  localparam int M  = N - K;
  localparam int CW = $clog2(M + 1);

  logic [1:0]        r_state;
  logic [M*N-1:0]    r_h;
  logic [N-1:0]      r_cw;
  logic [M-1:0]      r_syn;
  logic [ITER_W-1:0] r_iter;
  logic              r_ok;
`ifdef LDPC_FLIP_MASK_EN
  logic [N-1:0]      r_mask;
`endif

  logic [M-1:0]      w_syn;
  logic [N*CW-1:0]   w_unsat;
  logic [CW-1:0]     w_best;
  logic [N-1:0]      w_flip;

  ldpc_syndrome #(.N(N), .M(M), .CW(CW)) u_syndrome (
    .i_h        (r_h),
    .i_codeword (r_cw),
    .o_syndrome (w_syn),
    .o_unsat    (w_unsat)
  );

  // Strict greater-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    w_best = '0;
    w_flip = '0;
    for (int j = 0; j < N; j++) begin
      if (w_unsat[j*CW +: CW] > w_best) begin
        w_best    = w_unsat[j*CW +: CW];
        w_flip    = '0;
        w_flip[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_h     <= '0;
      r_cw    <= '0;
      r_syn   <= '0;
      r_iter  <= '0;
      r_ok    <= 1'b0;
`ifdef LDPC_FLIP_MASK_EN
      r_mask  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_en) begin
            r_cw    <= received;
            r_h     <= parity_check;
            r_iter  <= '0;
            r_ok    <= 1'b0;
`ifdef LDPC_FLIP_MASK_EN
            r_mask  <= '0;
`endif
            r_state <= ST_SYND;
          end
        end
        ST_SYND: begin
          r_syn   <= w_syn;
          r_state <= ST_EVAL;
        end
        ST_EVAL: begin
          if (r_syn == '0) begin
            r_ok    <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_iter == ITER_W'(MAX_ITER)) begin
            r_ok    <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            // r_cw is unchanged since SYND, so w_unsat reflects r_syn.
            r_cw    <= r_cw ^ w_flip;
`ifdef LDPC_FLIP_MASK_EN
            r_mask  <= r_mask ^ w_flip;
`endif
            r_iter  <= r_iter + ITER_W'(1);
            r_state <= ST_SYND;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign codeword = r_cw;
  assign syndrome = r_syn;
  assign iter     = r_iter;
  assign o_ok     = r_ok;
  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = (r_state == ST_DONE);
`ifdef LDPC_FLIP_MASK_EN
  assign flip_mask = r_mask;
`endif

endmodule
